// File: rtl/mtable_pkg.sv
// +----------------------------------------------------------------------------+
// | mtable_pkg : FSM state encoding and reference truth table for mtable_bist   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mtable_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRIVE = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // z = a ^ c over vec = {a,b,c}
    localparam logic [7:0] MTABLE_EXP = 8'h5A;

endpackage : mtable_pkg

`default_nettype wire

// File: rtl/mtable_bist.sv
// +----------------------------------------------------------------------------+
// | mtable_bist : walks every input vector of the mtable block, checks z, and   |
// | reports error count / pass. Optional MTABLE_BIST_FAIL_CAPTURE_EN records    |
// | the first failing vector. Rev 1.0                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module mtable_bist
    import mtable_pkg::*;
#(
    parameter int                  N_IN       = 3,
    parameter logic [2**N_IN-1:0]  EXP_TABLE  = MTABLE_EXP,
    parameter int                  SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic [N_IN-1:0]  dut_vec_o,
    input  logic             dut_z_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [N_IN:0]    err_cnt_o
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
    ,
    output logic             first_fail_vld_o,
    output logic [N_IN-1:0]  first_fail_vec_o
`endif
);

    localparam int              CW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] IDX_LAST    = '1;

    state_t            state_q,  state_d;
    logic [N_IN-1:0]   idx_q,    idx_d;
    logic [CW-1:0]     settle_q, settle_d;
    logic [N_IN:0]     err_q,    err_d;
    logic              pass_q,   pass_d;
    logic              w_mismatch;

`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
    logic              ff_vld_q, ff_vld_d;
    logic [N_IN-1:0]   ff_vec_q, ff_vec_d;
`endif

    assign w_mismatch = (state_q == ST_CHECK) && (dut_z_i != EXP_TABLE[idx_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
            ff_vld_q <= 1'b0;
            ff_vec_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
            ff_vld_q <= ff_vld_d;
            ff_vec_q <= ff_vec_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        err_d    = err_q;
        pass_d   = pass_q;
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
        ff_vld_d = ff_vld_q;
        ff_vec_d = ff_vec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    idx_d    = '0;
                    err_d    = '0;
                    pass_d   = 1'b0;
                    settle_d = '0;
                    state_d  = ST_DRIVE;
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
                    ff_vld_d = 1'b0;
`endif
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = ST_CHECK;
                end else begin
                    settle_d = settle_q + CW'(1);
                end
            end
            ST_CHECK: begin
                if (w_mismatch) begin
                    err_d = err_q + (N_IN+1)'(1);
                end
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
                if (w_mismatch && !ff_vld_q) begin
                    ff_vld_d = 1'b1;
                    ff_vec_d = idx_q;
                end
`endif
                // pass uses the count including this final check
                if (idx_q == IDX_LAST) begin
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + N_IN'(1);
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o    = (state_q != ST_IDLE);
        done_o    = (state_q == ST_DONE);
        dut_vec_o = (state_q == ST_IDLE) ? '0 : idx_q;
        pass_o    = pass_q;
        err_cnt_o = err_q;
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
        first_fail_vld_o = ff_vld_q;
        first_fail_vec_o = ff_vec_q;
`endif
    end

endmodule : mtable_bist

`default_nettype wire

// File: tb/tb_mtable_bist.sv
// +----------------------------------------------------------------------------+
// | tb_mtable_bist : two BIST instances (settle 1 and 3) driving a table-based  |
// | mtable stand-in, checked every cycle against a run-position model. Rev 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mtable_bist;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cur_tbl = 8'h5A;
    logic [7:0]  exp_tab = 8'h5A;

    logic [2:0]  vec [2];
    logic [1:0]  z;
    logic [1:0]  busy, done, pass;
    logic [3:0]  err [2];
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
    logic [1:0]  ff_vld;
    logic [2:0]  ff_vec [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // behavioural mtable stand-in: z looked up from the table under test
    assign z[0] = cur_tbl[vec[0]];
    assign z[1] = cur_tbl[vec[1]];

    mtable_bist u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start), .dut_vec_o(vec[0]), .dut_z_i(z[0]),
        .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .err_cnt_o(err[0])
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
        , .first_fail_vld_o(ff_vld[0]), .first_fail_vec_o(ff_vec[0])
`endif
    );

    mtable_bist #(.SETTLE_CYC(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start), .dut_vec_o(vec[1]), .dut_z_i(z[1]),
        .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .err_cnt_o(err[1])
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
        , .first_fail_vld_o(ff_vld[1]), .first_fail_vec_o(ff_vec[1])
`endif
    );

    function automatic int settle(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int run_len(input int i);
        return 8 * (settle(i) + 1);
    endfunction

    // mismatches whose check has completed k cycles into a run
    function automatic int model_err(input logic [7:0] t, input int s, input int k);
        int c = 0;
        for (int j = 0; j < 8; j++)
            if ((t[j] != exp_tab[j]) && (j * (s + 1) + s < k)) c++;
        return c;
    endfunction

    function automatic int model_ff(input logic [7:0] t, input int s, input int k);
        for (int j = 0; j < 8; j++)
            if ((t[j] != exp_tab[j]) && (j * (s + 1) + s < k)) return j;
        return -1;
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, i, act, exp, $time);
        end
    endtask

    // model: position k within a run (k = posedges since the start edge)
    bit         m_act  [2];
    int         m_k    [2];
    bit         m_pass [2];
    logic [7:0] m_tbl  [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i]  <= 1'b0;
                m_k[i]    <= 0;
                m_pass[i] <= 1'b0;
                m_tbl[i]  <= 8'h5A;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_act[i]) begin
                    if (m_k[i] == run_len(i)) begin
                        m_act[i]  <= 1'b0;
                        m_k[i]    <= run_len(i) + 1;
                        m_pass[i] <= (model_err(m_tbl[i], settle(i), run_len(i) + 1) == 0);
                    end else begin
                        m_k[i] <= m_k[i] + 1;
                    end
                end else if (start) begin
                    m_act[i] <= 1'b1;
                    m_k[i]   <= 0;
                    m_tbl[i] <= cur_tbl;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                automatic int  s      = settle(i);
                automatic int  l      = run_len(i);
                automatic bit  in_done = m_act[i] && (m_k[i] == l);
                automatic int  ff     = model_ff(m_tbl[i], s, m_k[i]);
                chk("busy", i, int'(busy[i]), int'(m_act[i]));
                chk("done", i, int'(done[i]), int'(in_done));
                chk("err_cnt", i, int'(err[i]), model_err(m_tbl[i], s, m_k[i]));
                if (!in_done)
                    chk("pass", i, int'(pass[i]), m_act[i] ? 0 : int'(m_pass[i]));
                if (m_act[i] && m_k[i] < l)
                    chk("dut_vec", i, int'(vec[i]), m_k[i] / (s + 1));
                else if (!m_act[i])
                    chk("dut_vec_idle", i, int'(vec[i]), 0);
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
                chk("ff_vld", i, int'(ff_vld[i]), int'(ff >= 0));
                if (ff >= 0) chk("ff_vec", i, int'(ff_vec[i]), ff);
`else
                if (ff < -1) chk("ff_model", i, ff, -1);
`endif
            end
        end
    end

    // one run on both instances; p1..p3 are edges (relative to the start edge) with extra start
    task automatic run(input logic [7:0] tbl, input int e_err, input int e_ff,
                       input int p1, input int p2, input int p3);
        int cnt = 0;
        int da = -1;
        int db = -1;
        int na = 0;
        cur_tbl = tbl;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        while (cnt < 48) begin
            @(negedge clk);
            if (done[0]) begin
                na++;
                if (da < 0) da = cnt;
            end
            if (done[1] && db < 0) db = cnt;
            start = (cnt + 1 == p1) || (cnt + 1 == p2) || (cnt + 1 == p3);
            @(posedge clk);
            cnt++;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_latency_s1", 0, da, 16);
        chk("done_latency_s3", 1, db, 32);
        chk("done_count", 0, na, 1);
        for (int i = 0; i < 2; i++) begin
            chk("final_err", i, int'(err[i]), e_err);
            chk("final_pass", i, int'(pass[i]), int'(e_err == 0));
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
            chk("final_ff_vld", i, int'(ff_vld[i]), int'(e_ff >= 0));
            if (e_ff >= 0) chk("final_ff_vec", i, int'(ff_vec[i]), e_ff);
`endif
        end
        if (e_ff < -1) chk("ff_arg", 0, e_ff, -1);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_busy"}, i, int'(busy[i]), 0);
            chk({tag, "_done"}, i, int'(done[i]), 0);
            chk({tag, "_pass"}, i, int'(pass[i]), 0);
            chk({tag, "_err"}, i, int'(err[i]), 0);
            chk({tag, "_vec"}, i, int'(vec[i]), 0);
`ifdef MTABLE_BIST_FAIL_CAPTURE_EN
            chk({tag, "_ff_vld"}, i, int'(ff_vld[i]), 0);
            chk({tag, "_ff_vec"}, i, int'(ff_vec[i]), 0);
`endif
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("reset");

        run(8'h5A, 0, -1, -1, -1, -1);     // golden z = a ^ c
        run(8'h3C, 4, 1, -1, -1, -1);      // z = a ^ b : vec 1,2,5,6
        run(8'hFF, 4, 0, -1, -1, -1);      // stuck-at-1 : vec 0,2,5,7

        // asynchronous reset in the middle of a failing run
        cur_tbl = 8'hFF;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("midrun_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(8'h5A, 0, -1, -1, -1, -1);

        run(8'h5A, 0, -1, 3, 16, 17);      // start while busy, incl. DONE
        run(8'h3C, 4, 1, 3, 16, 17);

        for (int r = 0; r < 6; r++) begin
            automatic logic [7:0] t    = 8'($urandom);
            automatic logic [7:0] diff = t ^ exp_tab;
            automatic int         ff   = -1;
            for (int j = 7; j >= 0; j--) if (diff[j]) ff = j;
            run(t, $countones(diff), ff, -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mtable_bist

`default_nettype wire
